// File: rtl/snake_pattern_monitor.sv
// snake_pattern_monitor
// Watches the 8-bit snake LED pattern bus, decodes each pattern to its step
// index and locks onto the 10-step sequence. Steps 4/7, 5/8 and 6/9 share
// bus values, so the step is resolved from the expected next position rather
// than from the value alone. Reports out-of-order patterns, bus stalls, an
// error count and a count of completed sequences.

module snake_pattern_monitor #(
  parameter int TIMEOUT = 33554432,  // cycles without a bus change before lock is dropped
  parameter int TO_W    = 26         // idle counter width, must hold TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pat_in,
  output logic       locked,
  output logic [3:0] step,
  output logic       err_seq,
  output logic       err_timeout,
  output logic [7:0] err_count,
  output logic [7:0] cycle_count
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0]      PAT_STEP0 = 8'b0001_1111;
  localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT - 1);

  // Bus value the generator drives for a given step; 0x00 for anything else,
  // which never matches because 0x00 is not a legal pattern.
  function automatic logic [7:0] f_pattern(input logic [3:0] s);
    logic [7:0] v;
    case (s)
      4'd0:    v = 8'b0001_1111;
      4'd1:    v = 8'b1110_0101;
      4'd2:    v = 8'b0011_1011;
      4'd3:    v = 8'b1100_1101;
      4'd4:    v = 8'b0111_0011;
      4'd5:    v = 8'b1000_1111;
      4'd6:    v = 8'b1011_0101;
      4'd7:    v = 8'b0111_0011;
      4'd8:    v = 8'b1000_1111;
      4'd9:    v = 8'b1011_0101;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_t          r_state, w_state_next;
  logic [7:0]      r_pat_d1, r_pat_d2;
  logic [TO_W-1:0] r_idle, w_idle_next;
  logic [3:0]      r_step, w_step_next;
  logic            r_err_seq, w_err_seq_next;
  logic            r_err_timeout, w_err_timeout_next;
  logic [7:0]      r_err_count, w_err_count_next;
  logic [7:0]      r_cycle_count, w_cycle_count_next;

  logic            w_chg;
  logic [3:0]      w_exp;
  logic            w_exp_match;
  logic [7:0]      w_err_count_inc;

  // A new bus value shows up as a difference across the two-stage pipe.
  assign w_chg           = (r_pat_d1 != r_pat_d2);
  assign w_exp           = (r_step == 4'd9) ? 4'd0 : r_step + 4'd1;
  assign w_exp_match     = (r_pat_d1 == f_pattern(w_exp));
  assign w_err_count_inc = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;

  // Input pipe: two register stages on the observed bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat_d1 <= 8'h00;
      r_pat_d2 <= 8'h00;
    end else begin
      r_pat_d1 <= pat_in;
      r_pat_d2 <= r_pat_d1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_idle        <= '0;
      r_step        <= 4'd0;
      r_err_seq     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_count   <= 8'h00;
      r_cycle_count <= 8'h00;
    end else begin
      r_state       <= w_state_next;
      r_idle        <= w_idle_next;
      r_step        <= w_step_next;
      r_err_seq     <= w_err_seq_next;
      r_err_timeout <= w_err_timeout_next;
      r_err_count   <= w_err_count_next;
      r_cycle_count <= w_cycle_count_next;
    end
  end

  // Next-state logic: hunt for step 0, then follow the sequence; a bus change
  // takes priority over a stall timeout landing on the same cycle.
  always_comb begin
    w_state_next       = r_state;
    w_idle_next        = r_idle;
    w_step_next        = r_step;
    w_err_seq_next     = 1'b0;
    w_err_timeout_next = 1'b0;
    w_err_count_next   = r_err_count;
    w_cycle_count_next = r_cycle_count;

    case (r_state)
      ST_HUNT: begin
        w_idle_next = '0;
        w_step_next = 4'd0;
        if (w_chg && (r_pat_d1 == PAT_STEP0)) begin
          w_state_next = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
        if (w_chg) begin
          w_idle_next = '0;
          if (w_exp_match) begin
            w_step_next = w_exp;
            if (w_exp == 4'd0) begin
              w_cycle_count_next = r_cycle_count + 8'd1;
            end
          end else begin
            w_err_seq_next   = 1'b1;
            w_err_count_next = w_err_count_inc;
            w_step_next      = 4'd0;
            // A stray step-0 pattern resynchronises instead of dropping lock.
            if (r_pat_d1 != PAT_STEP0) begin
              w_state_next = ST_HUNT;
            end
          end
        end else if (r_idle == IDLE_LAST) begin
          w_err_timeout_next = 1'b1;
          w_err_count_next   = w_err_count_inc;
          w_state_next       = ST_HUNT;
          w_step_next        = 4'd0;
          w_idle_next        = '0;
        end else begin
          w_idle_next = r_idle + TO_W'(1);
        end
      end

      default: begin
        w_state_next = ST_HUNT;
        w_idle_next  = '0;
        w_step_next  = 4'd0;
      end
    endcase
  end

  assign locked      = (r_state == ST_LOCKED);
  assign step        = r_step;
  assign err_seq     = r_err_seq;
  assign err_timeout = r_err_timeout;
  assign err_count   = r_err_count;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_snake_pattern_monitor.sv
// Bench for snake_pattern_monitor. Stimulus drives directed pattern vectors
// and pushes the hand-computed output state (with the cycle it must appear)
// into a queue; a monitor pops one entry each time the DUT outputs change and
// compares both the values and the cycle.

module tb_snake_pattern_monitor;

  localparam int TMO = 16;

  logic       clk;
  logic       reset;
  logic [7:0] pat_in;
  logic       locked;
  logic [3:0] step;
  logic       err_seq;
  logic       err_timeout;
  logic [7:0] err_count;
  logic [7:0] cycle_count;

  snake_pattern_monitor #(
    .TIMEOUT (TMO),
    .TO_W    (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pat_in      (pat_in),
    .locked      (locked),
    .step        (step),
    .err_seq     (err_seq),
    .err_timeout (err_timeout),
    .err_count   (err_count),
    .cycle_count (cycle_count)
  );

  typedef struct {
    int         cyc;
    logic       lk;
    logic [3:0] st;
    logic       es;
    logic       et;
    logic [7:0] ec;
    logic [7:0] cc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        last_t;
  int         cyc;
  int         last_n;
  int         n_vec;
  int         n_miss;
  logic [7:0] pat_tab [10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges; a value driven at the negedge seen with cyc=n is
  // sampled on edge n+1 and shows on the outputs after edge n+2.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit same_out(input ev_t a, input ev_t b);
    return (a.lk === b.lk) && (a.st === b.st) && (a.es === b.es) &&
           (a.et === b.et) && (a.ec === b.ec) && (a.cc === b.cc);
  endfunction

  // Queue an expected output state for cycle c (only if it is a change);
  // a pulse also queues its fall one cycle later.
  task automatic expect_at(input int c, input logic lk, input logic [3:0] st,
                           input logic es, input logic et,
                           input logic [7:0] ec, input logic [7:0] cc);
    ev_t t;
    t.cyc = c; t.lk = lk; t.st = st; t.es = es; t.et = et; t.ec = ec; t.cc = cc;
    if (!same_out(t, last_t)) begin
      exp_q.push_back(t);
      last_t = t;
    end
    if (es || et) begin
      t.cyc = c + 1; t.es = 1'b0; t.et = 1'b0;
      exp_q.push_back(t);
      last_t = t;
    end
  endtask

  // Drive one pattern (called at a negedge) and hold it for 'hold' cycles.
  task automatic send(input logic [7:0] p, input int hold, input logic lk,
                      input logic [3:0] st, input logic es,
                      input logic [7:0] ec, input logic [7:0] cc);
    last_n = cyc;
    pat_in = p;
    expect_at(cyc + 2, lk, st, es, 1'b0, ec, cc);
    repeat (hold) @(negedge clk);
  endtask

  // Monitor: one comparison per output change, plus any expected change
  // whose cycle has passed without being seen.
  initial begin : monitor
    ev_t obs, prev, e;
    prev.cyc = 0; prev.lk = 1'b1; prev.st = 4'hF; prev.es = 1'b1;
    prev.et = 1'b1; prev.ec = 8'hFF; prev.cc = 8'hFF;
    forever begin
      @(negedge clk);
      obs.cyc = cyc; obs.lk = locked; obs.st = step; obs.es = err_seq;
      obs.et = err_timeout; obs.ec = err_count; obs.cc = cycle_count;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_miss++;
        $display("FAIL missed_change cyc=%0d: outputs stayed lk=%0b st=%0d es=%0b et=%0b ec=%0d cc=%0d, required lk=%0b st=%0d es=%0b et=%0b ec=%0d cc=%0d at cyc=%0d",
                 cyc, obs.lk, obs.st, obs.es, obs.et, obs.ec, obs.cc,
                 e.lk, e.st, e.es, e.et, e.ec, e.cc, e.cyc);
      end
      if (!same_out(obs, prev)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_change cyc=%0d: got lk=%0b st=%0d es=%0b et=%0b ec=%0d cc=%0d, required no change",
                   cyc, obs.lk, obs.st, obs.es, obs.et, obs.ec, obs.cc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || !same_out(obs, e)) begin
            n_miss++;
            $display("FAIL out_change cyc=%0d: got lk=%0b st=%0d es=%0b et=%0b ec=%0d cc=%0d, required cyc=%0d lk=%0b st=%0d es=%0b et=%0b ec=%0d cc=%0d",
                     cyc, obs.lk, obs.st, obs.es, obs.et, obs.ec, obs.cc,
                     e.cyc, e.lk, e.st, e.es, e.et, e.ec, e.cc);
          end else begin
            $display("ev cyc=%0d lk=%0b st=%0d es=%0b et=%0b ec=%0d cc=%0d ok",
                     cyc, obs.lk, obs.st, obs.es, obs.et, obs.ec, obs.cc);
          end
        end
      end
      prev = obs;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete, required completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    n_vec  = 0;
    n_miss = 0;
    pat_tab[0] = 8'b0001_1111; pat_tab[1] = 8'b1110_0101;
    pat_tab[2] = 8'b0011_1011; pat_tab[3] = 8'b1100_1101;
    pat_tab[4] = 8'b0111_0011; pat_tab[5] = 8'b1000_1111;
    pat_tab[6] = 8'b1011_0101; pat_tab[7] = 8'b0111_0011;
    pat_tab[8] = 8'b1000_1111; pat_tab[9] = 8'b1011_0101;

    last_t.cyc = 0; last_t.lk = 1'b1; last_t.st = 4'hF; last_t.es = 1'b1;
    last_t.et = 1'b1; last_t.ec = 8'hFF; last_t.cc = 8'hFF;

    // Reset state: all outputs 0 after the first edge.
    reset  = 1'b1;
    pat_in = 8'h00;
    expect_at(1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Full sequence 0..9,0.
    for (int k = 0; k < 10; k++) send(pat_tab[k], 4, 1'b1, 4'(k), 1'b0, 8'd0, 8'd0);
    send(pat_tab[0], 4, 1'b1, 4'd0, 1'b0, 8'd0, 8'd1);

    // Stall: timeout exactly TMO cycles after the last change.
    expect_at(last_n + 2 + TMO, 1'b0, 4'd0, 1'b0, 1'b1, 8'd1, 8'd1);
    repeat (TMO) @(negedge clk);

    // Mid-sequence start: nothing until the step-0 pattern.
    for (int k = 3; k < 8; k++) send(pat_tab[k], 4, 1'b0, 4'd0, 1'b0, 8'd1, 8'd1);
    send(pat_tab[0], 4, 1'b1, 4'd0, 1'b0, 8'd1, 8'd1);

    // Repeated values resolved by position (6 -> 01110011 is step 7).
    for (int k = 1; k < 10; k++) send(pat_tab[k], 3, 1'b1, 4'(k), 1'b0, 8'd1, 8'd1);
    send(pat_tab[0], 3, 1'b1, 4'd0, 1'b0, 8'd1, 8'd2);

    // Step-0 pattern at step 6: error, resync, cycle count unchanged.
    for (int k = 1; k < 7; k++) send(pat_tab[k], 3, 1'b1, 4'(k), 1'b0, 8'd1, 8'd2);
    send(pat_tab[0], 3, 1'b1, 4'd0, 1'b1, 8'd2, 8'd2);

    // Invalid value at step 2: error and lock dropped.
    send(pat_tab[1], 3, 1'b1, 4'd1, 1'b0, 8'd2, 8'd2);
    send(pat_tab[2], 3, 1'b1, 4'd2, 1'b0, 8'd2, 8'd2);
    send(8'hFF, 3, 1'b0, 4'd0, 1'b1, 8'd3, 8'd2);

    // Changes 15 and exactly 16 cycles after the previous one: no timeout.
    send(pat_tab[0], 15, 1'b1, 4'd0, 1'b0, 8'd3, 8'd2);
    send(pat_tab[1], 16, 1'b1, 4'd1, 1'b0, 8'd3, 8'd2);
    send(pat_tab[2], 4, 1'b1, 4'd2, 1'b0, 8'd3, 8'd2);
    send(pat_tab[3], 4, 1'b1, 4'd3, 1'b0, 8'd3, 8'd2);

    // One-cycle patterns are evaluated; returning to 6 after a 7 glitch
    // is a second change and out of order.
    send(pat_tab[4], 1, 1'b1, 4'd4, 1'b0, 8'd3, 8'd2);
    send(pat_tab[5], 1, 1'b1, 4'd5, 1'b0, 8'd3, 8'd2);
    send(pat_tab[6], 4, 1'b1, 4'd6, 1'b0, 8'd3, 8'd2);
    send(pat_tab[7], 1, 1'b1, 4'd7, 1'b0, 8'd3, 8'd2);
    send(pat_tab[6], 4, 1'b0, 4'd0, 1'b1, 8'd4, 8'd2);

    // Reset mid-lock at step 5 with a change still in the pipe.
    send(pat_tab[0], 3, 1'b1, 4'd0, 1'b0, 8'd4, 8'd2);
    for (int k = 1; k < 6; k++) send(pat_tab[k], 3, 1'b1, 4'(k), 1'b0, 8'd4, 8'd2);
    pat_in = pat_tab[6];
    @(negedge clk);
    reset = 1'b1;
    expect_at(cyc + 1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 6; k < 10; k++) send(pat_tab[k], 3, 1'b0, 4'd0, 1'b0, 8'd0, 8'd0);
    send(pat_tab[0], 3, 1'b1, 4'd0, 1'b0, 8'd0, 8'd0);

    // 300 sequence errors: err_count saturates at 255.
    for (int i = 1; i <= 300; i++) begin
      send(pat_tab[2], 2, 1'b0, 4'd0, 1'b1, (i > 255) ? 8'd255 : 8'(i), 8'd0);
      send(pat_tab[0], 2, 1'b1, 4'd0, 1'b0, (i > 255) ? 8'd255 : 8'(i), 8'd0);
    end

    // 256 full sequences: cycle_count wraps back to 0.
    for (int i = 1; i <= 256; i++) begin
      for (int k = 1; k < 10; k++) send(pat_tab[k], 2, 1'b1, 4'(k), 1'b0, 8'd255, 8'(i - 1));
      send(pat_tab[0], 2, 1'b1, 4'd0, 1'b0, 8'd255, 8'(i));
    end

    // Timeout while saturated: pulse fires, count stays 255.
    expect_at(last_n + 2 + TMO, 1'b0, 4'd0, 1'b0, 1'b1, 8'd255, 8'd0);
    repeat (TMO + 10) @(negedge clk);

    // Anything still queued was never observed.
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL never_seen: required cyc=%0d lk=%0b st=%0d es=%0b et=%0b ec=%0d cc=%0d, got no such change",
               e.cyc, e.lk, e.st, e.es, e.et, e.ec, e.cc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
